// File: rtl/runway_sequencer.sv
// runway_sequencer
//   Sequences the runway-lights pattern engine. A prescaler turns clk into a
//   one-cycle step strobe (no divided clocks), the raw switch request is
//   synchronised, and mode changes are held pending until a pattern cycle
//   completes so the lights never jump mid-pattern.
//
//   Optional feature macro: RUNWAY_FREEZE_EN (adds the freeze input; while
//   freeze=1 the prescaler, step and phase pause, request tracking continues).
//
// Ports
//   clk      in   1  system clock
//   reset    in   1  synchronous, active-high reset
//   w        in   2  raw request: 00 calm, 10 wind-right, 01 wind-left, 11 invalid
//   freeze   in   1  pause stepping (RUNWAY_FREEZE_EN builds only)
//   step     out  1  one-cycle pulse, datapath advances its lights on it
//   mode     out  2  committed pattern mode
//   phase    out  2  step index within the current pattern
//   busy     out  1  a mode change is pending
//   req_err  out  1  synchronised request is the invalid code 11
module runway_sequencer #(
  parameter int TICK_DIV    = 25000000,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_HOLD    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] w,
`ifdef RUNWAY_FREEZE_EN
  input  logic       freeze,
`endif
  output logic       step,
  output logic [1:0] mode,
  output logic [1:0] phase,
  output logic       busy,
  output logic       req_err
);

  localparam int CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HOLD_W = $clog2(MIN_HOLD + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MIN_HOLD);

  typedef enum logic {RUN = 1'b0, PEND = 1'b1} state_t;

  state_t            state;
  logic [1:0]        sync_q [SYNC_STAGES];
  logic [1:0]        req;
  logic [1:0]        pending;
  logic [CNT_W-1:0]  cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              run_en;
  logic              tick;
  logic [1:0]        phase_last;
  logic              boundary;
  logic              req_valid;
  logic              hold_ok;

`ifdef RUNWAY_FREEZE_EN
  assign run_en = !freeze;
`else
  assign run_en = 1'b1;
`endif

  // Stage: request synchroniser
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 2'b00;
    end else begin
      sync_q[0] <= w;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign req       = sync_q[SYNC_STAGES-1];
  assign req_valid = (req != 2'b11);

  // Stage: prescaler, holds its count while frozen
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (run_en) begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

  assign tick       = run_en && (cnt == CNT_LAST);
  assign phase_last = (mode == 2'b00) ? 2'd1 : 2'd2;
  assign boundary   = tick && (phase == phase_last);
  // This boundary itself counts toward the hold requirement.
  assign hold_ok    = (32'(hold_cnt) + 32'd1) >= 32'(MIN_HOLD);

  // Stage: sequencer FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      step     <= 1'b0;
      mode     <= 2'b00;
      phase    <= 2'd0;
      busy     <= 1'b0;
      req_err  <= 1'b0;
      pending  <= 2'b00;
      hold_cnt <= '0;
    end else begin
      step    <= tick;
      req_err <= !req_valid;
      if (tick) phase <= (phase == phase_last) ? 2'd0 : phase + 2'd1;
      if (boundary && hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + HOLD_W'(1);

      case (state)
        RUN: begin
          if (req_valid && req != mode) begin
            state   <= PEND;
            pending <= req;
            busy    <= 1'b1;
          end
        end
        PEND: begin
          // A commit uses the pending value registered before this edge,
          // even if the request moves in the same cycle.
          if (boundary && hold_ok) begin
            mode     <= pending;
            phase    <= 2'd0;
            hold_cnt <= '0;
            busy     <= 1'b0;
            state    <= RUN;
          end else if (req_valid && req == mode) begin
            busy  <= 1'b0;
            state <= RUN;
          end else if (req_valid && req != pending) begin
            pending <= req;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_runway_sequencer.sv
module tb_runway_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] w = 2'b00;
  logic       freeze = 1'b0;
  logic       step_a, busy_a, req_err_a;
  logic [1:0] mode_a, phase_a;
  logic       step_b, busy_b, req_err_b;
  logic [1:0] mode_b, phase_b;
  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  runway_sequencer #(.TICK_DIV(4), .SYNC_STAGES(2), .MIN_HOLD(1)) dut_a (
    .clk(clk), .reset(reset), .w(w),
`ifdef RUNWAY_FREEZE_EN
    .freeze(freeze),
`endif
    .step(step_a), .mode(mode_a), .phase(phase_a), .busy(busy_a), .req_err(req_err_a)
  );

  runway_sequencer #(.TICK_DIV(4), .SYNC_STAGES(2), .MIN_HOLD(2)) dut_b (
    .clk(clk), .reset(reset), .w(w),
`ifdef RUNWAY_FREEZE_EN
    .freeze(1'b0),
`endif
    .step(step_b), .mode(mode_b), .phase(phase_b), .busy(busy_b), .req_err(req_err_b)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    w = 2'b00; reset = 1'b1;
    cyc(3);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [1:0] exp_ph [4] = '{2'd1, 2'd0, 2'd1, 2'd0};
    w = 2'b00; reset = 1'b1;
    cyc(3);
    vecs++; if ({step_a, mode_a, phase_a, busy_a, req_err_a} !== 7'b0) begin
      errs++; $display("FAIL reset_outputs got %b exp 0000000", {step_a, mode_a, phase_a, busy_a, req_err_a});
    end
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc(3);
      vecs++; if (step_a !== 1'b0) begin errs++; $display("FAIL reset_gap%0d step got %b exp 0", k, step_a); end
      cyc(1);
      vecs++; if (step_a !== 1'b1) begin errs++; $display("FAIL reset_step%0d got %b exp 1", k, step_a); end
      vecs++; if (phase_a !== exp_ph[k]) begin errs++; $display("FAIL reset_phase%0d got %0d exp %0d", k, phase_a, exp_ph[k]); end
      vecs++; if (mode_a !== 2'b00) begin errs++; $display("FAIL reset_mode%0d got %b exp 00", k, mode_a); end
    end
  endtask

  task automatic test_change();
    logic [1:0] exp_ph [3] = '{2'd1, 2'd2, 2'd0};
    cyc(1);  // prescaler now 1, phase 0
    w = 2'b10;
    cyc(2);
    vecs++; if (busy_a !== 1'b0) begin errs++; $display("FAIL change_busy_early got %b exp 0", busy_a); end
    cyc(1);
    vecs++; if (busy_a !== 1'b1) begin errs++; $display("FAIL change_busy got %b exp 1", busy_a); end
    vecs++; if ({step_a, mode_a, phase_a} !== 5'b1_00_01) begin
      errs++; $display("FAIL change_pre got %b exp 10001", {step_a, mode_a, phase_a});
    end
    cyc(4);
    vecs++; if ({step_a, mode_a, phase_a, busy_a} !== 6'b1_10_00_0) begin
      errs++; $display("FAIL change_commit got %b exp 110000", {step_a, mode_a, phase_a, busy_a});
    end
    for (int k = 0; k < 3; k++) begin
      cyc(4);
      vecs++; if ({step_a, phase_a} !== {1'b1, exp_ph[k]}) begin
        errs++; $display("FAIL change_phase%0d got step %b phase %0d exp step 1 phase %0d", k, step_a, phase_a, exp_ph[k]);
      end
    end
  endtask

  task automatic test_cancel();
    do_reset();
    w = 2'b01;
    cyc(1);
    w = 2'b00;
    cyc(1);
    vecs++; if (busy_a !== 1'b0) begin errs++; $display("FAIL cancel_busy_early got %b exp 0", busy_a); end
    cyc(1);
    vecs++; if (busy_a !== 1'b1) begin errs++; $display("FAIL cancel_busy_set got %b exp 1", busy_a); end
    cyc(1);
    vecs++; if ({busy_a, step_a, phase_a, mode_a} !== 6'b0_1_01_00) begin
      errs++; $display("FAIL cancel_clear got %b exp 010100", {busy_a, step_a, phase_a, mode_a});
    end
    cyc(4);
    vecs++; if ({busy_a, step_a, phase_a, mode_a} !== 6'b0_1_00_00) begin
      errs++; $display("FAIL cancel_boundary got %b exp 010000", {busy_a, step_a, phase_a, mode_a});
    end
  endtask

  task automatic test_invalid();
    w = 2'b11;
    cyc(2);
    vecs++; if (req_err_a !== 1'b0) begin errs++; $display("FAIL invalid_early got %b exp 0", req_err_a); end
    cyc(1);
    vecs++; if ({req_err_a, busy_a} !== 2'b10) begin errs++; $display("FAIL invalid_flag got %b exp 10", {req_err_a, busy_a}); end
    cyc(1);
    vecs++; if ({req_err_a, busy_a, step_a, phase_a, mode_a} !== 7'b1_0_1_01_00) begin
      errs++; $display("FAIL invalid_step got %b exp 1010100", {req_err_a, busy_a, step_a, phase_a, mode_a});
    end
    w = 2'b00;
    cyc(2);
    vecs++; if (req_err_a !== 1'b1) begin errs++; $display("FAIL invalid_hold got %b exp 1", req_err_a); end
    cyc(1);
    vecs++; if (req_err_a !== 1'b0) begin errs++; $display("FAIL invalid_clear got %b exp 0", req_err_a); end
    cyc(1);
    vecs++; if ({busy_a, step_a, phase_a, mode_a} !== 6'b0_1_00_00) begin
      errs++; $display("FAIL invalid_after got %b exp 010000", {busy_a, step_a, phase_a, mode_a});
    end
  endtask

  task automatic test_hold();
    do_reset();
    w = 2'b10;
    cyc(3);
    vecs++; if (busy_b !== 1'b1) begin errs++; $display("FAIL hold_busy1 got %b exp 1", busy_b); end
    cyc(5);
    vecs++; if ({step_b, busy_b, mode_b, phase_b} !== 6'b1_1_00_00) begin
      errs++; $display("FAIL hold_skip1 got %b exp 110000", {step_b, busy_b, mode_b, phase_b});
    end
    cyc(8);
    vecs++; if ({step_b, busy_b, mode_b, phase_b} !== 6'b1_0_10_00) begin
      errs++; $display("FAIL hold_commit1 got %b exp 101000", {step_b, busy_b, mode_b, phase_b});
    end
    w = 2'b01;
    cyc(3);
    vecs++; if (busy_b !== 1'b1) begin errs++; $display("FAIL hold_busy2 got %b exp 1", busy_b); end
    cyc(9);
    vecs++; if ({step_b, busy_b, mode_b, phase_b} !== 6'b1_1_10_00) begin
      errs++; $display("FAIL hold_skip2 got %b exp 111000", {step_b, busy_b, mode_b, phase_b});
    end
    cyc(12);
    vecs++; if ({step_b, busy_b, mode_b, phase_b} !== 6'b1_0_01_00) begin
      errs++; $display("FAIL hold_commit2 got %b exp 100100", {step_b, busy_b, mode_b, phase_b});
    end
  endtask

  task automatic test_reset_pend();
    do_reset();
    w = 2'b10;
    cyc(8);
    w = 2'b01;
    cyc(3);
    vecs++; if ({busy_a, mode_a} !== 3'b1_10) begin
      errs++; $display("FAIL rpend_pre got %b exp 110", {busy_a, mode_a});
    end
    reset = 1'b1;
    cyc(1);
    vecs++; if ({step_a, mode_a, phase_a, busy_a, req_err_a} !== 7'b0) begin
      errs++; $display("FAIL rpend_reset got %b exp 0000000", {step_a, mode_a, phase_a, busy_a, req_err_a});
    end
    reset = 1'b0;
    do_reset();
  endtask

`ifdef RUNWAY_FREEZE_EN
  task automatic test_freeze();
    int steps;
    do_reset();
    cyc(2);  // prescaler at 2
    freeze = 1'b1;
    steps = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      if (step_a === 1'b1) steps++;
    end
    freeze = 1'b0;
    vecs++; if (steps !== 0) begin errs++; $display("FAIL freeze_steps got %0d exp 0", steps); end
    vecs++; if (phase_a !== 2'd0) begin errs++; $display("FAIL freeze_phase got %0d exp 0", phase_a); end
    cyc(1);
    vecs++; if (step_a !== 1'b0) begin errs++; $display("FAIL freeze_resume_gap got %b exp 0", step_a); end
    cyc(1);
    vecs++; if ({step_a, phase_a} !== 3'b1_01) begin
      errs++; $display("FAIL freeze_resume got %b exp 101", {step_a, phase_a});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_change();
    test_cancel();
    test_invalid();
    test_hold();
    test_reset_pend();
`ifdef RUNWAY_FREEZE_EN
    test_freeze();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
